// File: rtl/neosd_pkg.sv
// Shared definitions for the neosd DAT receive/transmit paths:
// receiver state encoding, CRC16-CCITT polynomial and a single-bit CRC step.
package neosd_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_START = 3'd1,
        DATA       = 3'd2,
        CRC        = 3'd3,
        END        = 3'd4
    } dat_rx_state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;

    // One serial CRC16 step: shift left, fold in the polynomial when the
    // feedback (MSB xor incoming bit) is set.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/neosd_crc16.sv
// Serial CRC16-CCITT engine (x^16+x^12+x^5+1, init 0). One bit per enabled
// clock; clr_i has priority over en_i. Used by both DAT RX and DAT TX paths.
module neosd_crc16
    import neosd_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_reg;

    // CRC register: clear to zero, or advance by one bit when enabled.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            crc_reg <= '0;
        end else if (clr_i) begin
            crc_reg <= '0;
        end else if (en_i) begin
            crc_reg <= crc16_step(crc_reg, bit_i);
        end
    end

    assign crc_o = crc_reg;

endmodule

// File: rtl/neosd_dat_rx.sv
// Host-side SD DAT0 block receiver. Hunts the start bit, deserialises
// BLOCK_BYTES bytes MSB-first, captures the 16-bit CRC, checks the end bit.
// All line sampling happens on the shared slow-clock strobe clkstrb_i.
// Optional build macro NEOSD_DAT_RX_TIMEOUT_EN: bounds the start-bit hunt to
// TIMEOUT_STRB strobes and reports expiry on timeout_o.
module neosd_dat_rx
    import neosd_pkg::*;
#(
    parameter int BLOCK_BYTES  = 512,
    parameter int TIMEOUT_STRB = 65535
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       clkstrb_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       dat_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       crc_err_o,
    output logic       end_err_o,
    output logic       timeout_o
);

    localparam int                BC_W      = $clog2(BLOCK_BYTES + 1);
    localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BLOCK_BYTES - 1);

    dat_rx_state_t   state_reg, state_next;
    logic [7:0]      shift_reg, shift_next;
    logic [2:0]      bit_cnt_reg, bit_cnt_next;
    logic [BC_W-1:0] byte_cnt_reg, byte_cnt_next;
    logic [3:0]      crc_bit_cnt_reg, crc_bit_cnt_next;
    logic [15:0]     rx_crc_reg, rx_crc_next;
    logic [7:0]      byte_reg, byte_next;
    logic            byte_valid_reg, byte_valid_next;
    logic            done_reg, done_next;
    logic            crc_err_reg, crc_err_next;
    logic            end_err_reg, end_err_next;

    logic            crc_clr;
    logic            crc_en;
    logic [15:0]     crc_calc;

`ifdef NEOSD_DAT_RX_TIMEOUT_EN
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_STRB);
    logic [15:0]     tmo_cnt_reg, tmo_cnt_next;
    logic [15:0]     tmo_cnt_inc;
    logic            timeout_reg, timeout_next;

    assign tmo_cnt_inc = tmo_cnt_reg + 16'd1;
`else
    // Without the timeout build the limit has no consumer.
    logic [15:0]     unused_tmo_limit;
    assign unused_tmo_limit = 16'(TIMEOUT_STRB);
`endif

    // Computed CRC over the data bits only; frozen outside DATA.
    neosd_crc16 u_crc (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (crc_clr),
        .en_i   (crc_en),
        .bit_i  (dat_i),
        .crc_o  (crc_calc)
    );

    // Next-state and datapath decode; abort overrides everything else.
    always_comb begin
        state_next       = state_reg;
        shift_next       = shift_reg;
        bit_cnt_next     = bit_cnt_reg;
        byte_cnt_next    = byte_cnt_reg;
        crc_bit_cnt_next = crc_bit_cnt_reg;
        rx_crc_next      = rx_crc_reg;
        byte_next        = byte_reg;
        byte_valid_next  = 1'b0;
        done_next        = 1'b0;
        crc_err_next     = crc_err_reg;
        end_err_next     = end_err_reg;
        crc_clr          = 1'b0;
        crc_en           = 1'b0;
`ifdef NEOSD_DAT_RX_TIMEOUT_EN
        tmo_cnt_next     = tmo_cnt_reg;
        timeout_next     = timeout_reg;
`endif

        if (abort_i) begin
            // Drop the block silently: no done, flags untouched, pending byte lost.
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        state_next   = WAIT_START;
                        crc_err_next = 1'b0;
                        end_err_next = 1'b0;
`ifdef NEOSD_DAT_RX_TIMEOUT_EN
                        timeout_next = 1'b0;
                        tmo_cnt_next = '0;
`endif
                    end
                end

                WAIT_START: begin
                    if (clkstrb_i) begin
                        if (!dat_i) begin
                            // Start bit seen; a start bit on the last allowed strobe still wins.
                            state_next    = DATA;
                            bit_cnt_next  = '0;
                            byte_cnt_next = '0;
                            crc_clr       = 1'b1;
                        end
`ifdef NEOSD_DAT_RX_TIMEOUT_EN
                        else begin
                            tmo_cnt_next = tmo_cnt_inc;
                            if (tmo_cnt_inc == TMO_LIMIT) begin
                                timeout_next = 1'b1;
                                done_next    = 1'b1;
                                state_next   = IDLE;
                            end
                        end
`endif
                    end
                end

                DATA: begin
                    if (clkstrb_i) begin
                        shift_next   = {shift_reg[6:0], dat_i};
                        crc_en       = 1'b1;
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            byte_next       = {shift_reg[6:0], dat_i};
                            byte_valid_next = 1'b1;
                            byte_cnt_next   = byte_cnt_reg + BC_W'(1);
                            if (byte_cnt_reg == LAST_BYTE) begin
                                state_next       = CRC;
                                crc_bit_cnt_next = '0;
                            end
                        end
                    end
                end

                CRC: begin
                    if (clkstrb_i) begin
                        rx_crc_next      = {rx_crc_reg[14:0], dat_i};
                        crc_bit_cnt_next = crc_bit_cnt_reg + 4'd1;
                        if (crc_bit_cnt_reg == 4'd15) begin
                            state_next = END;
                        end
                    end
                end

                END: begin
                    if (clkstrb_i) begin
                        end_err_next = ~dat_i;
                        crc_err_next = (rx_crc_reg != crc_calc);
                        done_next    = 1'b1;
                        state_next   = IDLE;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State, counters, capture registers and registered status outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg       <= IDLE;
            shift_reg       <= '0;
            bit_cnt_reg     <= '0;
            byte_cnt_reg    <= '0;
            crc_bit_cnt_reg <= '0;
            rx_crc_reg      <= '0;
            byte_reg        <= '0;
            byte_valid_reg  <= 1'b0;
            done_reg        <= 1'b0;
            crc_err_reg     <= 1'b0;
            end_err_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            shift_reg       <= shift_next;
            bit_cnt_reg     <= bit_cnt_next;
            byte_cnt_reg    <= byte_cnt_next;
            crc_bit_cnt_reg <= crc_bit_cnt_next;
            rx_crc_reg      <= rx_crc_next;
            byte_reg        <= byte_next;
            byte_valid_reg  <= byte_valid_next;
            done_reg        <= done_next;
            crc_err_reg     <= crc_err_next;
            end_err_reg     <= end_err_next;
        end
    end

`ifdef NEOSD_DAT_RX_TIMEOUT_EN
    // Start-bit hunt timer and its sticky flag.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tmo_cnt_reg <= '0;
            timeout_reg <= 1'b0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign timeout_o = timeout_reg;
`else
    assign timeout_o = 1'b0;
`endif

    assign byte_o       = byte_reg;
    assign byte_valid_o = byte_valid_reg;
    assign busy_o       = (state_reg != IDLE);
    assign done_o       = done_reg;
    assign crc_err_o    = crc_err_reg;
    assign end_err_o    = end_err_reg;

endmodule

// File: tb/tb_neosd_dat_rx.sv
// Self-checking bench for neosd_dat_rx (BLOCK_BYTES=4, TIMEOUT_STRB=10).
// Frames are built from a byte-wise CRC16-CCITT model; a negedge monitor
// collects emitted bytes and done pulses for comparison.
`timescale 1ns/1ps
module tb_neosd_dat_rx;

    localparam int BB = 4;
    localparam int TS = 10;

    logic       clk_i     = 1'b0;
    logic       rstn_i    = 1'b0;
    logic       clkstrb_i = 1'b0;
    logic       start_i   = 1'b0;
    logic       abort_i   = 1'b0;
    logic       dat_i     = 1'b1;
    logic [7:0] byte_o;
    logic       byte_valid_o, busy_o, done_o, crc_err_o, end_err_o, timeout_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] got_q [$];
    int         done_cnt = 0;
    logic [7:0] tx_data [BB];
    logic       tx_bits [$];

    neosd_dat_rx #(.BLOCK_BYTES(BB), .TIMEOUT_STRB(TS)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .clkstrb_i    (clkstrb_i),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .dat_i        (dat_i),
        .byte_o       (byte_o),
        .byte_valid_o (byte_valid_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .crc_err_o    (crc_err_o),
        .end_err_o    (end_err_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (byte_valid_o) got_q.push_back(byte_o);
        if (done_o) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic do_abort();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
    endtask

    // Byte-wise CRC16-CCITT (poly 0x1021, init 0) over tx_data.
    function automatic logic [15:0] ref_crc();
        logic [15:0] c;
        c = 16'h0000;
        for (int i = 0; i < BB; i++) begin
            c = c ^ {tx_data[i], 8'h00};
            for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    task automatic rand_data();
        for (int i = 0; i < BB; i++) tx_data[i] = 8'($urandom_range(0, 255));
    endtask

    // Line image: idle ones, start bit, data MSB-first, CRC MSB-first, end bit.
    task automatic build_bits(input int pre, input int flip, input logic endb);
        logic [15:0] c;
        c = ref_crc();
        if (flip >= 0) c[15-flip] = ~c[15-flip];
        tx_bits.delete();
        for (int i = 0; i < pre; i++) tx_bits.push_back(1'b1);
        tx_bits.push_back(1'b0);
        for (int i = 0; i < BB; i++)
            for (int k = 7; k >= 0; k--) tx_bits.push_back(tx_data[i][k]);
        for (int k = 15; k >= 0; k--) tx_bits.push_back(c[k]);
        tx_bits.push_back(endb);
    endtask

    // One bit per four clocks, strobe on the fourth; optional start_i pulse mid-bit.
    task automatic strobe_bit(input logic b, input logic pulse_start);
        dat_i   = b;
        start_i = pulse_start;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        clkstrb_i = 1'b1;
        tick();
        clkstrb_i = 1'b0;
    endtask

    task automatic send_bits(input int from, input int upto, input int pulse_at);
        for (int i = from; i < upto; i++) strobe_bit(tx_bits[i], i == pulse_at);
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        repeat (3) tick();
        n_tests++;
        if ({byte_o, byte_valid_o, busy_o, done_o, crc_err_o, end_err_o, timeout_o} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_hold: outputs=%h required 0", {byte_o, byte_valid_o, busy_o, done_o, crc_err_o, end_err_o, timeout_o});
        end
        rstn_i = 1'b1;
        repeat (2) tick();
        n_tests++;
        if ({busy_o, done_o, byte_valid_o, crc_err_o, end_err_o, timeout_o} !== 6'h0) begin
            n_fail++;
            $display("FAIL reset_release: flags=%b required 000000", {busy_o, done_o, byte_valid_o, crc_err_o, end_err_o, timeout_o});
        end
    endtask

    task automatic test_directed();
        int d0;
        tx_data[0] = 8'hA5; tx_data[1] = 8'h3C; tx_data[2] = 8'h00; tx_data[3] = 8'hFF;
        got_q.delete();
        d0 = done_cnt;
        do_start();
        n_tests++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL directed_busy: got %b required 1", busy_o); end
        build_bits(2, -1, 1'b1);
        send_bits(0, tx_bits.size(), -1);
        repeat (2) tick();
        n_tests++;
        if (got_q.size() != BB) begin n_fail++; $display("FAIL directed_count: got %0d bytes required %0d", got_q.size(), BB); end
        for (int i = 0; i < BB && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== tx_data[i]) begin n_fail++; $display("FAIL directed_byte%0d: got %h required %h", i, got_q[i], tx_data[i]); end
        end
        n_tests++;
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL directed_done: got %0d pulses required 1", done_cnt - d0); end
        n_tests++;
        if ({crc_err_o, end_err_o, timeout_o, busy_o} !== 4'b0000) begin
            n_fail++; $display("FAIL directed_status: crc/end/tmo/busy=%b required 0000", {crc_err_o, end_err_o, timeout_o, busy_o});
        end
        $display("[TB] directed frame A5 3C 00 FF: %0d bytes, crc_err=%b end_err=%b", got_q.size(), crc_err_o, end_err_o);
    endtask

    task automatic test_crc_flip();
        int d0;
        tx_data[0] = 8'hA5; tx_data[1] = 8'h3C; tx_data[2] = 8'h00; tx_data[3] = 8'hFF;
        d0 = done_cnt;
        do_start();
        build_bits(1, 15, 1'b1);
        send_bits(0, tx_bits.size(), -1);
        repeat (2) tick();
        n_tests++;
        if (done_cnt - d0 != 1 || crc_err_o !== 1'b1 || end_err_o !== 1'b0) begin
            n_fail++; $display("FAIL crc_flip: done=%0d crc_err=%b end_err=%b required 1 1 0", done_cnt - d0, crc_err_o, end_err_o);
        end
        repeat (10) tick();
        n_tests++;
        if (crc_err_o !== 1'b1) begin n_fail++; $display("FAIL crc_flip_held: got %b required 1", crc_err_o); end
        do_start();
        n_tests++;
        if (crc_err_o !== 1'b0) begin n_fail++; $display("FAIL crc_flip_clear: got %b required 0", crc_err_o); end
        do_abort();
        $display("[TB] crc flip last bit: error flagged then cleared by start");
    endtask

    task automatic test_end_err();
        int d0;
        d0 = done_cnt;
        do_start();
        build_bits(0, -1, 1'b0);
        send_bits(0, tx_bits.size(), -1);
        repeat (2) tick();
        n_tests++;
        if (done_cnt - d0 != 1 || end_err_o !== 1'b1 || crc_err_o !== 1'b0) begin
            n_fail++; $display("FAIL end_err: done=%0d end_err=%b crc_err=%b required 1 1 0", done_cnt - d0, end_err_o, crc_err_o);
        end
        $display("[TB] end bit 0: end_err=%b crc_err=%b", end_err_o, crc_err_o);
    endtask

    task automatic test_random_frames();
        int d0, flip, pre;
        logic endb;
        for (int n = 0; n < 10; n++) begin
            rand_data();
            flip = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1;
            endb = ($urandom_range(0, 3) != 0);
            pre  = int'($urandom_range(0, 3));
            got_q.delete();
            d0 = done_cnt;
            do_start();
            build_bits(pre, flip, endb);
            send_bits(0, tx_bits.size(), -1);
            repeat (2) tick();
            n_tests++;
            if (got_q.size() != BB) begin n_fail++; $display("FAIL rand%0d_count: got %0d required %0d", n, got_q.size(), BB); end
            for (int i = 0; i < BB && i < got_q.size(); i++) begin
                n_tests++;
                if (got_q[i] !== tx_data[i]) begin n_fail++; $display("FAIL rand%0d_byte%0d: got %h required %h", n, i, got_q[i], tx_data[i]); end
            end
            n_tests++;
            if (done_cnt - d0 != 1 || crc_err_o !== (flip >= 0) || end_err_o !== ~endb) begin
                n_fail++;
                $display("FAIL rand%0d_status: done=%0d crc_err=%b end_err=%b required 1 %b %b", n, done_cnt - d0, crc_err_o, end_err_o, (flip >= 0), ~endb);
            end
            $display("[TB] random frame %0d: data=%h %h %h %h flip=%0d end=%b", n, tx_data[0], tx_data[1], tx_data[2], tx_data[3], flip, endb);
        end
    endtask

    task automatic test_abort();
        int d0;
        rand_data();
        got_q.delete();
        d0 = done_cnt;
        do_start();
        build_bits(1, -1, 1'b1);
        send_bits(0, 2 + 16, -1);
        do_abort();
        n_tests++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b required 0", busy_o); end
        send_bits(2 + 16, tx_bits.size(), -1);
        repeat (2) tick();
        n_tests++;
        if (got_q.size() != 2 || done_cnt != d0) begin
            n_fail++; $display("FAIL abort_quiet: bytes=%0d done=%0d required 2 0", got_q.size(), done_cnt - d0);
        end
        // Abort in the same cycle as the strobe that would complete byte 0.
        got_q.delete();
        do_start();
        build_bits(0, -1, 1'b1);
        send_bits(0, 8, -1);
        dat_i = tx_bits[8];
        tick(); tick(); tick();
        clkstrb_i = 1'b1;
        abort_i   = 1'b1;
        tick();
        clkstrb_i = 1'b0;
        abort_i   = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (got_q.size() != 0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL abort_same_cycle: bytes=%0d busy=%b required 0 0", got_q.size(), busy_o);
        end
        // Fresh block after abort.
        rand_data();
        got_q.delete();
        d0 = done_cnt;
        do_start();
        build_bits(1, -1, 1'b1);
        send_bits(0, tx_bits.size(), -1);
        repeat (2) tick();
        n_tests++;
        if (got_q.size() != BB || done_cnt - d0 != 1 || crc_err_o !== 1'b0) begin
            n_fail++; $display("FAIL abort_recover: bytes=%0d done=%0d crc_err=%b required %0d 1 0", got_q.size(), done_cnt - d0, crc_err_o, BB);
        end
        for (int i = 0; i < BB && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== tx_data[i]) begin n_fail++; $display("FAIL abort_recover_byte%0d: got %h required %h", i, got_q[i], tx_data[i]); end
        end
        $display("[TB] abort mid-block and on byte strobe, then clean block");
    endtask

    task automatic test_timeout();
        int d0;
`ifdef NEOSD_DAT_RX_TIMEOUT_EN
        d0 = done_cnt;
        do_start();
        for (int i = 0; i < TS - 1; i++) strobe_bit(1'b1, 1'b0);
        tick();
        n_tests++;
        if (done_cnt != d0 || busy_o !== 1'b1 || timeout_o !== 1'b0) begin
            n_fail++; $display("FAIL timeout_early: done=%0d busy=%b tmo=%b required 0 1 0", done_cnt - d0, busy_o, timeout_o);
        end
        strobe_bit(1'b1, 1'b0);
        tick();
        n_tests++;
        if (done_cnt - d0 != 1 || busy_o !== 1'b0 || timeout_o !== 1'b1) begin
            n_fail++; $display("FAIL timeout_fire: done=%0d busy=%b tmo=%b required 1 0 1", done_cnt - d0, busy_o, timeout_o);
        end
        do_start();
        n_tests++;
        if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b required 0", timeout_o); end
        rand_data();
        got_q.delete();
        d0 = done_cnt;
        build_bits(TS - 1, -1, 1'b1);
        send_bits(0, tx_bits.size(), -1);
        repeat (2) tick();
        n_tests++;
        if (got_q.size() != BB || done_cnt - d0 != 1 || timeout_o !== 1'b0 || crc_err_o !== 1'b0) begin
            n_fail++; $display("FAIL timeout_last_strobe: bytes=%0d done=%0d tmo=%b crc_err=%b required %0d 1 0 0", got_q.size(), done_cnt - d0, timeout_o, crc_err_o, BB);
        end
        $display("[TB] timeout after %0d strobes, start bit on final strobe accepted", TS);
`else
        d0 = done_cnt;
        do_start();
        for (int i = 0; i < 4 * TS; i++) strobe_bit(1'b1, 1'b0);
        n_tests++;
        if (done_cnt != d0 || busy_o !== 1'b1 || timeout_o !== 1'b0) begin
            n_fail++; $display("FAIL wait_forever: done=%0d busy=%b tmo=%b required 0 1 0", done_cnt - d0, busy_o, timeout_o);
        end
        rand_data();
        got_q.delete();
        build_bits(0, -1, 1'b1);
        send_bits(0, tx_bits.size(), -1);
        repeat (2) tick();
        n_tests++;
        if (got_q.size() != BB || done_cnt - d0 != 1 || timeout_o !== 1'b0) begin
            n_fail++; $display("FAIL wait_forever_rx: bytes=%0d done=%0d tmo=%b required %0d 1 0", got_q.size(), done_cnt - d0, timeout_o, BB);
        end
        $display("[TB] no timeout build: waited %0d strobes then received block", 4 * TS);
`endif
    endtask

    task automatic test_between_strobes();
        int d0;
        rand_data();
        got_q.delete();
        d0 = done_cnt;
        do_start();
        dat_i = 1'b0;
        repeat (20) tick();
        build_bits(2, -1, 1'b1);
        send_bits(0, tx_bits.size(), 20);
        repeat (2) tick();
        n_tests++;
        if (got_q.size() != BB || done_cnt - d0 != 1 || crc_err_o !== 1'b0 || end_err_o !== 1'b0) begin
            n_fail++; $display("FAIL between_strobes: bytes=%0d done=%0d crc_err=%b end_err=%b required %0d 1 0 0", got_q.size(), done_cnt - d0, crc_err_o, end_err_o, BB);
        end
        for (int i = 0; i < BB && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== tx_data[i]) begin n_fail++; $display("FAIL between_strobes_byte%0d: got %h required %h", i, got_q[i], tx_data[i]); end
        end
        $display("[TB] line low between strobes and start_i while busy ignored");
    endtask

    task automatic test_async_reset();
        int d0;
        rand_data();
        tx_data[0] = 8'hA5;
        got_q.delete();
        do_start();
        build_bits(1, -1, 1'b1);
        send_bits(0, 14, -1);
        #2;
        rstn_i = 1'b0;
        #1;
        n_tests++;
        if ({byte_o, byte_valid_o, busy_o, done_o, crc_err_o, end_err_o, timeout_o} !== 14'h0) begin
            n_fail++; $display("FAIL async_reset: outputs=%h required 0", {byte_o, byte_valid_o, busy_o, done_o, crc_err_o, end_err_o, timeout_o});
        end
        repeat (2) tick();
        rstn_i = 1'b1;
        got_q.delete();
        d0 = done_cnt;
        send_bits(14, tx_bits.size(), -1);
        repeat (2) tick();
        n_tests++;
        if (got_q.size() != 0 || done_cnt != d0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_idle: bytes=%0d done=%0d busy=%b required 0 0 0", got_q.size(), done_cnt - d0, busy_o);
        end
        $display("[TB] async reset mid-data returned to idle");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_crc_flip();
        test_end_err();
        test_random_frames();
        test_abort();
        test_timeout();
        test_between_strobes();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
